// File: rtl/bus_timer.sv
// Bus-slave timer: 32-bit up-counter with programmable expiry, periodic/one-shot mode and a sticky IRQ flag.
// Optional wait states before rdy_ are compiled in with `define BUS_TIMER_WAIT_EN (count set by WAIT_CYCLES).
module bus_timer #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_,
  output logic        irq
);

`ifdef BUS_TIMER_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);
  logic [3:0]  r_wait_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

  state_t      r_state;
  logic        r_rw;
  logic [1:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_rdy_n;
  logic [31:0] r_rd_data;
  logic        r_start;
  logic        r_periodic;
  logic        r_flag;
  logic [31:0] r_expr;
  logic [31:0] r_count;

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_use_live;
  logic        w_rw;
  logic [1:0]  w_addr;
  logic [31:0] w_wdata;
  logic        w_wr;
  logic        w_expire;
  logic [31:0] w_rd_val;

  assign w_accept = (r_state == S_IDLE) && !cs_ && !as_;
  // Zero-wait accesses commit on the accepting edge, so they use the live bus inputs.
  assign w_use_live = (r_state == S_IDLE);
`ifdef BUS_TIMER_WAIT_EN
  assign w_enter_resp = (w_accept && (LP_WAIT == 4'd0)) ||
                        ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));
`else
  assign w_enter_resp = w_accept;
`endif
  assign w_rw     = w_use_live ? rw      : r_rw;
  assign w_addr   = w_use_live ? addr    : r_addr;
  assign w_wdata  = w_use_live ? wr_data : r_wdata;
  assign w_wr     = w_enter_resp && !w_rw;
  assign w_expire = r_start && (r_count == r_expr);

  always_comb begin
    w_rd_val = 32'd0;
    case (w_addr)
      2'd0: w_rd_val = {30'd0, r_periodic, r_start};
      2'd1: w_rd_val = {31'd0, r_flag};
      2'd2: w_rd_val = r_expr;
      2'd3: w_rd_val = r_count;
      default: w_rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
`ifdef BUS_TIMER_WAIT_EN
      r_wait_cnt <= 4'd0;
`endif
      r_rw       <= 1'b0;
      r_addr     <= 2'd0;
      r_wdata    <= 32'd0;
      r_rdy_n    <= 1'b1;
      r_rd_data  <= 32'd0;
      r_start    <= 1'b0;
      r_periodic <= 1'b0;
      r_flag     <= 1'b0;
      r_expr     <= 32'd0;
      r_count    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rw    <= rw;
          r_addr  <= addr;
          r_wdata <= wr_data;
`ifdef BUS_TIMER_WAIT_EN
          if (LP_WAIT != 4'd0) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= 4'(LP_WAIT - 4'd1);
          end else begin
            r_state <= S_RESP;
          end
`else
          r_state <= S_RESP;
`endif
        end
`ifdef BUS_TIMER_WAIT_EN
        S_WAIT: if (r_wait_cnt == 4'd0) r_state <= S_RESP;
                else r_wait_cnt <= 4'(r_wait_cnt - 4'd1);
`endif
        S_RESP: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_resp) begin
        r_rdy_n   <= 1'b0;
        r_rd_data <= w_rw ? w_rd_val : 32'd0;
      end else if (r_state == S_RESP) begin
        r_rdy_n   <= 1'b1;
        r_rd_data <= 32'd0;
      end

      // Bus writes take priority over the timer's own updates, except that expiry always sets FLAG.
      if (w_wr && (w_addr == 2'd3)) r_count <= w_wdata;
      else if (w_expire)            r_count <= 32'd0;
      else if (r_start)             r_count <= r_count + 32'd1;

      if (w_wr && (w_addr == 2'd0)) begin
        r_start    <= w_wdata[0];
        r_periodic <= w_wdata[1];
      end else if (w_expire && !r_periodic) begin
        r_start <= 1'b0;
      end

      if (w_expire)                      r_flag <= 1'b1;
      else if (w_wr && (w_addr == 2'd1)) r_flag <= w_wdata[0];

      if (w_wr && (w_addr == 2'd2)) r_expr <= w_wdata;
    end
  end

  assign rd_data = r_rd_data;
  assign rdy_    = r_rdy_n;
  assign irq     = r_flag;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: bus transactions scored through a queue, timer behaviour
// predicted from the edge on which each register write commits.
module tb_bus_timer;
`ifdef BUS_TIMER_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk;
  logic        reset;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;
  logic        irq;

  typedef struct {
    bit          rd;
    logic [31:0] exp;
  } sb_t;

  sb_t    sbq[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     g_ref = 0;
  longint g_base = 0;
  longint g_period = 1;

  bus_timer #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge. kind 1 predicts a running COUNTER read.
  task automatic bus(input bit rd, input logic [1:0] a, input logic [31:0] d, input int kind,
                     input logic [31:0] exp_v, input bit hold, output int commit);
    sb_t e;
    int  n;
    cs_ = 1'b0; as_ = 1'b0; rw = rd; addr = a; wr_data = d;
    commit = cyc + 1 + W;
    e.rd = rd;
    if (kind == 1) e.exp = 32'((g_base + (longint'(commit) - 1 - g_ref)) % g_period);
    else           e.exp = exp_v;
    sbq.push_back(e);
    @(negedge clk);
    if (!hold) begin cs_ = 1'b1; as_ = 1'b1; end
    n = 0;
    while (rdy_ !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    if (rdy_ === 1'b0 && sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.rd) chk("rd_data", rd_data, e.exp);
    end
    @(negedge clk);
    chk("rdy_single", {31'd0, rdy_}, 32'd1);
    chk("rd_clear", rd_data, 32'd0);
    cs_ = 1'b1; as_ = 1'b1;
  endtask

  task automatic wait_irq(input int exp_steps);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("irq_delay", 32'(n), 32'(exp_steps));
  endtask

  initial begin
    int c;
    int r;
    int lows;
    reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = 2'd0; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, rdy_}, 32'd1);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) bus(1'b1, 2'(i), 32'd0, 0, 32'd0, 1'b0, c);

    // Reset during an access: no commit, no rdy_ pulse, FSM back to IDLE.
    cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 2'd0; wr_data = 32'h3;
    if (W == 0) reset = 1'b1;
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1;
    if (W > 0) reset = 1'b1;
    lows = (rdy_ === 1'b0) ? 1 : 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rdy_ === 1'b0) lows++;
      @(negedge clk);
    end
    chk("rst_mid_rdy", 32'(lows), 32'd0);
    bus(1'b1, 2'd0, 32'd0, 0, 32'd0, 1'b0, c);

    bus(1'b0, 2'd2, 32'h5, 0, 32'd0, 1'b0, c);
    bus(1'b1, 2'd2, 32'd0, 0, 32'h5, 1'b0, c);

    // Strobe held through RESP must not be re-accepted.
    bus(1'b0, 2'd2, 32'h55, 0, 32'd0, 1'b1, c);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      if (rdy_ === 1'b0) lows++;
      @(negedge clk);
    end
    chk("hold_single", 32'(lows), 32'd0);
    bus(1'b1, 2'd2, 32'd0, 0, 32'h55, 1'b0, c);

    // Periodic, EXPR=3.
    bus(1'b0, 2'd2, 32'd3, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd0, 32'h3, 0, 32'd0, 1'b0, c);
    g_ref = c; g_base = 0; g_period = 4;
    wait_irq(3);
    for (int i = 0; i < 5; i++) bus(1'b1, 2'd3, 32'd0, 1, 32'd0, 1'b0, r);
    bus(1'b1, 2'd0, 32'd0, 0, 32'h3, 1'b0, c);
    bus(1'b0, 2'd0, 32'd0, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd1, 32'd0, 0, 32'd0, 1'b0, c);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // COUNTER write collides with an increment.
    bus(1'b0, 2'd2, 32'h1000, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd0, 32'h1, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd3, 32'h100, 0, 32'd0, 1'b0, c);
    g_ref = c; g_base = 64'h100; g_period = 64'h1001;
    bus(1'b1, 2'd3, 32'd0, 1, 32'd0, 1'b0, r);
    bus(1'b1, 2'd3, 32'd0, 1, 32'd0, 1'b0, r);
    bus(1'b0, 2'd0, 32'd0, 0, 32'd0, 1'b0, c);

    // One-shot, EXPR=2.
    bus(1'b0, 2'd3, 32'd0, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd2, 32'd2, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd0, 32'h1, 0, 32'd0, 1'b0, c);
    wait_irq(2);
    bus(1'b1, 2'd0, 32'd0, 0, 32'h0, 1'b0, c);
    bus(1'b1, 2'd3, 32'd0, 0, 32'h0, 1'b0, c);
    bus(1'b1, 2'd1, 32'd0, 0, 32'h1, 1'b0, c);
    chk("oneshot_irq", {31'd0, irq}, 32'd1);
    bus(1'b0, 2'd1, 32'd0, 0, 32'd0, 1'b0, c);
    chk("oneshot_irq_clr", {31'd0, irq}, 32'd0);

    // INTR=0 written on the expiry edge is lost to the expiry.
    bus(1'b0, 2'd3, 32'd0, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd2, 32'd7, 0, 32'd0, 1'b0, c);
    bus(1'b0, 2'd0, 32'h1, 0, 32'd0, 1'b0, r);
    while (cyc + 1 + W < r + 8) @(negedge clk);
    bus(1'b0, 2'd1, 32'd0, 0, 32'd0, 1'b0, c);
    chk("collide_edge", 32'(c), 32'(r + 8));
    chk("collide_irq", {31'd0, irq}, 32'd1);
    bus(1'b1, 2'd1, 32'd0, 0, 32'h1, 1'b0, c);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
